gold_code_generator: RTL and testbench

- Parametrised Gold-code (PRN spreading-code) generator for the GPS front end.
- Generalises the fixed 10-stage L1 C/A generator: LFSR length, both feedback polynomials, initial fill and code length are parameters.
- Adds chip-enable pacing, a config handshake, a programmable start code phase (fast-forward seek), epoch marking and a code-phase readout.
- Feeds the correlator/replica path, one chip per chip_en strobe.

---
 rtl/gold_code_generator.sv | 146 ++++++++++++++
 tb/tb_gold_code_generator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gold_code_generator.sv
// Parametrised Gold-code generator: two N-stage LFSRs, selectable G2 output taps, chip-enable
// pacing, start-phase seek, epoch marking and a next-chip phase readout.
module gold_code_generator #(
  parameter int unsigned       N        = 10,
  parameter logic [N-1:0]      G1_POLY  = 10'b1000000100,
  parameter logic [N-1:0]      G2_POLY  = 10'b1110100110,
  parameter logic [N-1:0]      INIT     = 10'b1111111111,
  parameter int unsigned       CODE_LEN = 1023,
  parameter int unsigned       PW       = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [N-1:0]  i_cfg_taps,
  input  logic [PW-1:0] i_cfg_phase,
  output logic          o_cfg_err,
  input  logic          i_chip_en,
  output logic          o_chip,
  output logic          o_chip_valid,
  output logic          o_epoch,
  output logic [PW-1:0] o_phase,
  output logic          o_busy
);

  typedef enum logic [1:0] {StIdle, StSeek, StRun} state_t;

  localparam logic [PW-1:0] LAST_PHASE = PW'(CODE_LEN - 1);

  state_t        r_state, w_state_next;
  logic [N-1:0]  r_g1, w_g1_next;
  logic [N-1:0]  r_g2, w_g2_next;
  logic [N-1:0]  r_taps, w_taps_next;
  logic [PW-1:0] r_phase, w_phase_next;
  logic [PW-1:0] r_offset, w_offset_next;
  logic          r_chip, w_chip_next;
  logic          r_chip_valid, w_chip_valid_next;
  logic          r_epoch, w_epoch_next;
  logic          r_cfg_err, w_cfg_err_next;

  logic          w_cfg_ready;
  logic          w_cfg_acc;
  logic          w_bad_phase;
  logic [PW-1:0] w_offset;
  logic [PW-1:0] w_phase_inc;
  logic [N-1:0]  w_g1_adv;
  logic [N-1:0]  w_g2_adv;
  logic          w_code;

  // Bit k-1 holds stage k, so shifting toward the MSB moves stage k into k+1.
  assign w_g1_adv    = {r_g1[N-2:0], ^(r_g1 & G1_POLY)};
  assign w_g2_adv    = {r_g2[N-2:0], ^(r_g2 & G2_POLY)};
  assign w_code      = r_g1[N-1] ^ (^(r_g2 & r_taps));
  assign w_phase_inc = r_phase + PW'(1);

  assign w_cfg_ready = (r_state != StSeek);
  assign w_cfg_acc   = i_cfg_valid & w_cfg_ready;
  assign w_bad_phase = (32'(i_cfg_phase) >= CODE_LEN);
  assign w_offset    = w_bad_phase ? '0 : i_cfg_phase;

  always_comb begin
    w_state_next      = r_state;
    w_g1_next         = r_g1;
    w_g2_next         = r_g2;
    w_taps_next       = r_taps;
    w_phase_next      = r_phase;
    w_offset_next     = r_offset;
    w_chip_next       = r_chip;
    w_chip_valid_next = 1'b0;
    w_epoch_next      = 1'b0;
    w_cfg_err_next    = 1'b0;

    if (w_cfg_acc) begin
      // A config in the same cycle as chip_en wins; that chip is dropped.
      w_taps_next    = i_cfg_taps;
      w_g1_next      = INIT;
      w_g2_next      = INIT;
      w_phase_next   = '0;
      w_offset_next  = w_offset;
      w_cfg_err_next = w_bad_phase;
      w_state_next   = (w_offset == '0) ? StRun : StSeek;
    end else begin
      unique case (r_state)
        StSeek: begin
          w_g1_next    = w_g1_adv;
          w_g2_next    = w_g2_adv;
          w_phase_next = w_phase_inc;
          if (w_phase_inc == r_offset) w_state_next = StRun;
        end
        StRun: begin
          if (i_chip_en) begin
            w_chip_next       = w_code;
            w_chip_valid_next = 1'b1;
            w_epoch_next      = (r_phase == '0);
            // Forced wrap at CODE_LEN truncates longer LFSR periods.
            if (r_phase == LAST_PHASE) begin
              w_g1_next    = INIT;
              w_g2_next    = INIT;
              w_phase_next = '0;
            end else begin
              w_g1_next    = w_g1_adv;
              w_g2_next    = w_g2_adv;
              w_phase_next = w_phase_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_g1         <= INIT;
      r_g2         <= INIT;
      r_taps       <= '0;
      r_phase      <= '0;
      r_offset     <= '0;
      r_chip       <= 1'b0;
      r_chip_valid <= 1'b0;
      r_epoch      <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_g1         <= w_g1_next;
      r_g2         <= w_g2_next;
      r_taps       <= w_taps_next;
      r_phase      <= w_phase_next;
      r_offset     <= w_offset_next;
      r_chip       <= w_chip_next;
      r_chip_valid <= w_chip_valid_next;
      r_epoch      <= w_epoch_next;
      r_cfg_err    <= w_cfg_err_next;
    end
  end

  assign o_cfg_ready  = w_cfg_ready;
  assign o_cfg_err    = r_cfg_err;
  assign o_chip       = r_chip;
  assign o_chip_valid = r_chip_valid;
  assign o_epoch      = r_epoch;
  assign o_phase      = r_phase;
  assign o_busy       = (r_state == StSeek);

endmodule

// File: tb/tb_gold_code_generator.sv
// Directed bench for gold_code_generator: vector table of configs plus hand-written
// sequences for period wrap, seek, mid-run reconfig and asynchronous reset.
module tb_gold_code_generator;

  localparam int CL = 1023;
  localparam logic [9:0] PRN1 = 10'b0000100010;
  localparam logic [9:0] PRN2 = 10'b0001000100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [9:0] cfg_taps = '0;
  logic [9:0] cfg_phase = '0;
  logic       chip_en = 1'b0;
  logic       cfg_ready, cfg_err, chip, chip_valid, epoch, busy;
  logic [9:0] phase;

  gold_code_generator dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_taps   (cfg_taps),
    .i_cfg_phase  (cfg_phase),
    .o_cfg_err    (cfg_err),
    .i_chip_en    (chip_en),
    .o_chip       (chip),
    .o_chip_valid (chip_valid),
    .o_epoch      (epoch),
    .o_phase      (phase),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit ref_seq [0:CL-1];
  bit cap_chip[0:2047];
  bit cap_ep  [0:2047];
  int cap_ph  [0:2047];
  int vld_bad, ph_bad, ep_bad, ready_bad;

  typedef struct {
    logic [9:0] taps;
    logic [9:0] ph;
    int         n;
    int         gap;
    logic [9:0] exp_bits;
    int         nbits;
    logic       exp_err;
    int         exp_seek;
    int         start;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Textbook C/A generator: G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10.
  task automatic model_fill(input logic [9:0] taps);
    bit g1[1:10];
    bit g2[1:10];
    bit o, f1, f2;
    for (int k = 1; k <= 10; k++) begin
      g1[k] = 1'b1;
      g2[k] = 1'b1;
    end
    for (int i = 0; i < CL; i++) begin
      o = g1[10];
      for (int k = 1; k <= 10; k++) if (taps[k-1]) o ^= g2[k];
      ref_seq[i] = o;
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int k = 10; k > 1; k--) begin
        g1[k] = g1[k-1];
        g2[k] = g2[k-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
  endtask

  task automatic configure(input logic [9:0] taps, input logic [9:0] ph,
                           output int seek_cycles, output int seek_vld, output logic err);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_taps  = taps;
    cfg_phase = ph;
    chip_en   = 1'b0;
    @(posedge clk);
    #1;
    cfg_valid   = 1'b0;
    err         = cfg_err;
    seek_cycles = 0;
    seek_vld    = 0;
    ready_bad   = 0;
    chip_en     = 1'b1;
    while (busy && seek_cycles < 2000) begin
      if (cfg_ready) ready_bad++;
      @(posedge clk);
      #1;
      seek_cycles++;
      if (chip_valid) seek_vld++;
    end
    chip_en = 1'b0;
  endtask

  task automatic run_chips(input int n, input int gap, input int start);
    vld_bad = 0;
    ph_bad  = 0;
    ep_bad  = 0;
    for (int i = 0; i < n; i++) begin
      chip_en = 1'b1;
      @(posedge clk);
      #1;
      chip_en = 1'b0;
      if (chip_valid !== 1'b1) vld_bad++;
      cap_chip[i] = chip;
      cap_ep[i]   = epoch;
      cap_ph[i]   = int'(phase);
      if (int'(phase) != (start + i + 1) % CL) ph_bad++;
      if (epoch !== ((start + i) % CL == 0)) ep_bad++;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        if (chip_valid || epoch || chip !== cap_chip[i]) vld_bad++;
      end
    end
  endtask

  task automatic cmp_model(input string name, input int n, input int start);
    int bad = 0;
    for (int i = 0; i < n; i++) if (cap_chip[i] != ref_seq[(start + i) % CL]) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int   sc, sv, cnt, ones, bad;
    logic err;

    vecs[0] = '{PRN1, 10'd0,    10, 0, 10'b1100100000, 10, 1'b0, 0, 0};
    vecs[1] = '{PRN2, 10'd0,    10, 0, 10'b1110010000, 10, 1'b0, 0, 0};
    vecs[2] = '{PRN1, 10'd5,     5, 0, 10'b0000000000,  5, 1'b0, 5, 5};
    vecs[3] = '{PRN1, 10'd1023, 10, 2, 10'b1100100000, 10, 1'b1, 0, 0};

    #12;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_chip_valid", chip_valid, 0);
    check("rst_chip", chip, 0);
    check("rst_epoch", epoch, 0);
    check("rst_phase", phase, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    chip_en = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chip_en = 1'b0;
    check("idle_chip_en_ignored", chip_valid, 0);

    for (int v = 0; v < 4; v++) begin
      model_fill(vecs[v].taps);
      configure(vecs[v].taps, vecs[v].ph, sc, sv, err);
      check($sformatf("v%0d_cfg_err", v), err, vecs[v].exp_err);
      check($sformatf("v%0d_seek_cycles", v), sc, vecs[v].exp_seek);
      check($sformatf("v%0d_seek_no_valid", v), sv, 0);
      check($sformatf("v%0d_seek_ready_low", v), ready_bad, 0);
      check($sformatf("v%0d_entry_phase", v), phase, vecs[v].start);
      run_chips(vecs[v].n, vecs[v].gap, vecs[v].start);
      bad = 0;
      for (int i = 0; i < vecs[v].nbits; i++) if (cap_chip[i] != vecs[v].exp_bits[9-i]) bad++;
      check($sformatf("v%0d_chip_bits", v), bad, 0);
      check($sformatf("v%0d_valid", v), vld_bad, 0);
      check($sformatf("v%0d_phase", v), ph_bad, 0);
      check($sformatf("v%0d_epoch", v), ep_bad, 0);
      cmp_model($sformatf("v%0d_model", v), vecs[v].n, vecs[v].start);
    end

    // Two full periods of PRN1.
    model_fill(PRN1);
    configure(PRN1, 10'd0, sc, sv, err);
    run_chips(2046, 0, 0);
    check("per_valid", vld_bad, 0);
    check("per_phase", ph_bad, 0);
    check("per_epoch", ep_bad, 0);
    cmp_model("per_model", 2046, 0);
    bad  = 0;
    ones = 0;
    cnt  = 0;
    for (int i = 0; i < CL; i++) begin
      if (cap_chip[i + CL] != cap_chip[i]) bad++;
      if (cap_chip[i]) ones++;
    end
    for (int i = 0; i < 2046; i++) if (cap_ep[i]) cnt++;
    check("per_repeat", bad, 0);
    check("per_balance", ones, 512);
    check("per_epoch_count", cnt, 2);
    check("per_epoch_1023", cap_ep[1023], 1);
    check("per_phase_1022", cap_ph[1021], 1022);
    check("per_phase_wrap", cap_ph[1022], 0);

    // Start at phase 5: next epoch after 1018 chips.
    configure(PRN1, 10'd5, sc, sv, err);
    check("seek5_cycles", sc, 5);
    run_chips(1019, 0, 5);
    cnt = 0;
    for (int i = 0; i < 1019; i++) if (cap_ep[i]) cnt++;
    check("seek5_epoch_at_1018", cap_ep[1018], 1);
    check("seek5_epoch_count", cnt, 1);
    cmp_model("seek5_model", 1019, 5);

    // Reconfigure mid-run together with chip_en.
    configure(PRN2, 10'd0, sc, sv, err);
    run_chips(3, 0, 0);
    cfg_valid = 1'b1;
    cfg_taps  = PRN1;
    cfg_phase = 10'd0;
    chip_en   = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chip_en   = 1'b0;
    check("reconf_chip_dropped", chip_valid, 0);
    check("reconf_phase", phase, 0);
    run_chips(10, 0, 0);
    cmp_model("reconf_model", 10, 0);
    check("reconf_epoch", ep_bad, 0);

    // Asynchronous reset mid-run.
    configure(PRN1, 10'd0, sc, sv, err);
    run_chips(1, 0, 0);
    chip_en = 1'b1;
    @(posedge clk);
    #1;
    check("arst_pre_chip", chip, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_chip_valid", chip_valid, 0);
    check("arst_chip", chip, 0);
    check("arst_phase", phase, 0);
    check("arst_cfg_ready", cfg_ready, 1);
    check("arst_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (chip_valid || phase != 0) cnt++;
    end
    chip_en = 1'b0;
    check("arst_chip_en_ignored", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
